control_fsm: RTL and testbench
==============================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-003 SHALL have port opcode, input, opcode_t (7 bits): the instr[6:0] field of the instruction register, produced by the instruction decode stage.
REQ-004 SHALL have port mem_ready, input, 1 bit: the memory has completed the current read or write this cycle.
REQ-005 SHALL have the following outputs:
- pc_update, 1 bit: PC write enable.
- branch, 1 bit: conditional PC write, qualified by the ALU zero flag outside this block.
- ir_write, 1 bit: instruction register load.
- reg_write, 1 bit: register file write enable.
- mem_write, 1 bit: data memory write.
- adr_src, 1 bit: memory address select; 0 = PC, 1 = ALU result.
REQ-006 SHALL have outputs result_src [1:0] (00 ALUOut, 01 memory data, 10 ALU result) and alu_op [1:0] (00 add, 01 subtract/compare, 10 funct-decoded), which drive the ALU decoder.
REQ-007 SHALL have outputs alu_src_a [1:0] (00 PC, 01 oldPC, 10 rs1 data, 11 zero) and alu_src_b [1:0] (00 rs2 data, 01 imm_ext, 10 constant 4).
REQ-008 SHALL have outputs state [3:0] (the current state encoding), illegal (1 bit) and retired [31:0] (count of completed instructions).

Function
REQ-009 SHALL use the following state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, LUI=11; codes 12-15 are unused.
REQ-010 SHALL decode all outputs except retired and illegal from the state register (Moore); any output not listed for a state is 0.
REQ-011 FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10; ir_write=pc_update=mem_ready; stay in FETCH while mem_ready=0, otherwise go to DECODE.
REQ-012 DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target); the next state is selected by opcode:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1101111 -> JAL
- 1100011 -> BEQ
- 0110111 -> LUI
- anything else -> FETCH
REQ-013 MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00; go to MEMREAD if opcode=0000011, otherwise go to MEMWRITE.
REQ-014 MEMREAD: adr_src=1, result_src=00; hold while mem_ready=0, otherwise go to MEMWB.
REQ-015 MEMWB: result_src=01, reg_write=1; go to FETCH.
REQ-016 MEMWRITE: adr_src=1, result_src=00, mem_write=1; hold (mem_write stays 1) while mem_ready=0, otherwise go to FETCH.
REQ-017 EXECR (alu_src_a=10, alu_src_b=00, alu_op=10) and EXECI (alu_src_a=10, alu_src_b=01, alu_op=10) SHALL each go to ALUWB.
REQ-018 ALUWB: result_src=00, reg_write=1; go to FETCH.
REQ-019 JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1; go to ALUWB.
REQ-020 BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1; go to FETCH.
REQ-021 LUI: alu_src_a=11, alu_src_b=01, alu_op=00; go to ALUWB.
REQ-022 illegal SHALL be a registered pulse that is 1 for exactly the one cycle following a DECODE cycle whose opcode is unrecognised; no write enable asserts for that instruction.
REQ-023 retired SHALL increment by 1, modulo 2^32 (0xFFFFFFFF wraps to 0), on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ; an illegal-opcode return to FETCH does not count.
REQ-024 An unused state code (12-15) SHALL transition to FETCH on the next edge, with all outputs 0 while in it.
REQ-025 opcode SHALL be sampled only in DECODE and MEMADR; opcode changes in any other state have no effect.
REQ-026 Instruction latencies from FETCH acceptance to the next FETCH SHALL be: lw 5 cycles and sw 4 cycles (each plus mem_ready stall cycles), R/I/JAL/LUI 4 cycles, beq 3 cycles.

Reset
REQ-027 While reset=0, state SHALL be FETCH and retired=0, illegal=0, independent of clk.
REQ-028 Reset asserted mid-instruction (e.g. in MEMWRITE) SHALL clear state to FETCH immediately, deasserting mem_write/reg_write combinationally.
REQ-029 After reset deasserts, the first rising edge SHALL evaluate FETCH with the current mem_ready.

Verification
REQ-030 R-type: reset, then opcode=0110011 with mem_ready=1 -> states 0,1,6,7,0; reg_write=1 only in state 7; retired=1.
REQ-031 lw with stalls: opcode=0000011, mem_ready low for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0; result_src=01 in state 4.
REQ-032 Fetch stall: mem_ready=0 for 3 cycles -> state stays 0, ir_write=pc_update=0; both are 1 in the cycle mem_ready=1.
REQ-033 Illegal: opcode=1111111 -> states 0,1,0; illegal=1 for one cycle; retired unchanged.
REQ-034 Reset mid-sw: reset=0 while state=5 -> state=0 and mem_write=0 before the next clk edge; retired=0.
REQ-035 Wrap: preload retired to 0xFFFFFFFF (force), complete a beq -> retired=0x00000000.

Source files
------------

// File: rtl/control_fsm.sv
// Multi-cycle RISC-V control unit: a Moore state machine that sequences
// fetch, decode, memory access, execute and write-back. It also reports
// unrecognised opcodes and counts retired instructions.

package control_fsm_pkg;

   typedef logic [6:0] opcode_t;

   // Opcodes recognised in DECODE
   localparam opcode_t OP_LOAD   = 7'b0000011;
   localparam opcode_t OP_STORE  = 7'b0100011;
   localparam opcode_t OP_RTYPE  = 7'b0110011;
   localparam opcode_t OP_ITYPE  = 7'b0010011;
   localparam opcode_t OP_JAL    = 7'b1101111;
   localparam opcode_t OP_BEQ    = 7'b1100011;
   localparam opcode_t OP_LUI    = 7'b0110111;

   // State encodings (12-15 unused)
   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECR    = 4'd6;
   localparam logic [3:0] S_ALUWB    = 4'd7;
   localparam logic [3:0] S_EXECI    = 4'd8;
   localparam logic [3:0] S_JAL      = 4'd9;
   localparam logic [3:0] S_BEQ      = 4'd10;
   localparam logic [3:0] S_LUI      = 4'd11;

endpackage

module control_fsm
   import control_fsm_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  opcode_t     opcode,
   input  logic        mem_ready,
   output logic        pc_update,
   output logic        branch,
   output logic        ir_write,
   output logic        reg_write,
   output logic        mem_write,
   output logic        adr_src,
   output logic [1:0]  result_src,
   output logic [1:0]  alu_op,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [3:0]  state,
   output logic        illegal,
   output logic [31:0] retired
);

   logic [3:0]  r_state;
   logic [3:0]  w_next_state;
   logic        w_opc_legal;
   logic        w_retire;
   logic        r_illegal;
   logic [31:0] r_retired;
   logic [31:0] w_retired_next;

   // State register; reset forces FETCH immediately, independent of clk
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; opcode is only consulted in DECODE and MEMADR
   always_comb begin
      w_next_state = S_FETCH;
      w_opc_legal  = 1'b0;
      w_retire     = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (mem_ready) begin
               w_next_state = S_DECODE;
            end else begin
               w_next_state = S_FETCH;
            end
         end
         S_DECODE: begin
            w_opc_legal = 1'b1;
            case (opcode)
               OP_LOAD:  w_next_state = S_MEMADR;
               OP_STORE: w_next_state = S_MEMADR;
               OP_RTYPE: w_next_state = S_EXECR;
               OP_ITYPE: w_next_state = S_EXECI;
               OP_JAL:   w_next_state = S_JAL;
               OP_BEQ:   w_next_state = S_BEQ;
               OP_LUI:   w_next_state = S_LUI;
               default: begin
                  w_next_state = S_FETCH;
                  w_opc_legal  = 1'b0;
               end
            endcase
         end
         S_MEMADR: begin
            if (opcode == OP_LOAD) begin
               w_next_state = S_MEMREAD;
            end else begin
               w_next_state = S_MEMWRITE;
            end
         end
         S_MEMREAD: begin
            if (mem_ready) begin
               w_next_state = S_MEMWB;
            end else begin
               w_next_state = S_MEMREAD;
            end
         end
         S_MEMWB: begin
            w_next_state = S_FETCH;
            w_retire     = 1'b1;
         end
         S_MEMWRITE: begin
            if (mem_ready) begin
               w_next_state = S_FETCH;
               w_retire     = 1'b1;
            end else begin
               w_next_state = S_MEMWRITE;
            end
         end
         S_EXECR:  w_next_state = S_ALUWB;
         S_EXECI:  w_next_state = S_ALUWB;
         S_ALUWB: begin
            w_next_state = S_FETCH;
            w_retire     = 1'b1;
         end
         S_JAL:    w_next_state = S_ALUWB;
         S_BEQ: begin
            w_next_state = S_FETCH;
            w_retire     = 1'b1;
         end
         S_LUI:    w_next_state = S_ALUWB;
         default:  w_next_state = S_FETCH;
      endcase
   end

   // Moore output decode; unused codes drive every output to 0
   always_comb begin
      pc_update  = 1'b0;
      branch     = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      result_src = 2'b00;
      alu_op     = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      case (r_state)
         S_FETCH: begin
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = mem_ready;
            pc_update  = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
         end
         S_BEQ: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            branch    = 1'b1;
         end
         S_LUI: begin
            alu_src_a = 2'b11;
            alu_src_b = 2'b01;
         end
         default: begin
            pc_update = 1'b0;
         end
      endcase
   end

   // Retired-instruction counter next value (wraps naturally at 2^32)
   always_comb begin
      if (w_retire) begin
         w_retired_next = r_retired + 32'd1;
      end else begin
         w_retired_next = r_retired;
      end
   end

   // Illegal-opcode pulse and retired counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_illegal <= 1'b0;
         r_retired <= 32'd0;
      end else begin
         r_illegal <= (r_state == S_DECODE) && !w_opc_legal;
         r_retired <= w_retired_next;
      end
   end

   assign state   = r_state;
   assign illegal = r_illegal;
   assign retired = r_retired;

endmodule

// File: tb/tb_control_fsm.sv
// Directed testbench for control_fsm: each task drives one scenario and
// compares the DUT against hand-computed state traces and output values.

module tb_control_fsm;

   logic        clk;
   logic        reset;
   logic [6:0]  opcode;
   logic        mem_ready;
   logic        pc_update, branch, ir_write, reg_write, mem_write, adr_src;
   logic [1:0]  result_src, alu_op, alu_src_a, alu_src_b;
   logic [3:0]  state;
   logic        illegal;
   logic [31:0] retired;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_retired = 32'd0;

   control_fsm dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pc_update(pc_update), .branch(branch), .ir_write(ir_write),
      .reg_write(reg_write), .mem_write(mem_write), .adr_src(adr_src),
      .result_src(result_src), .alu_op(alu_op), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .state(state), .illegal(illegal),
      .retired(retired)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Puts the DUT into reset across one rising edge, returns at a falling edge in FETCH
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      exp_retired = 32'd0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", state); end
      checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired got %0d expected 0", retired); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %0d expected 0", illegal); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_hold_state got %0d expected 0", state); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_rtype();
      logic [3:0] es [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
      logic       mr [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic       rw [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      opcode = 7'b0110011;
      for (int i = 0; i < 5; i++) begin
         mem_ready = mr[i];
         #1;
         checks++; if (state !== es[i]) begin errors++; $display("FAIL rtype_state step %0d got %0d expected %0d", i, state, es[i]); end
         checks++; if (reg_write !== rw[i]) begin errors++; $display("FAIL rtype_reg_write step %0d got %0d expected %0d", i, reg_write, rw[i]); end
         if (i == 0) begin
            checks++; if ({ir_write, pc_update} !== 2'b11) begin errors++; $display("FAIL rtype_fetch_we got %b expected 11", {ir_write, pc_update}); end
         end
         if (i == 2) begin
            checks++; if ({alu_src_a, alu_src_b, alu_op} !== 6'b10_00_10) begin errors++; $display("FAIL rtype_execr_ctl got %b expected 100010", {alu_src_a, alu_src_b, alu_op}); end
         end
         @(negedge clk);
      end
      exp_retired = exp_retired + 32'd1;
      checks++; if (retired !== exp_retired) begin errors++; $display("FAIL rtype_retired got %0d expected %0d", retired, exp_retired); end
   endtask

   task automatic test_lw_stall();
      logic [3:0] es [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
      logic       mr [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      opcode = 7'b0000011;
      for (int i = 0; i < 8; i++) begin
         mem_ready = mr[i];
         if (i == 3) opcode = 7'b1111111;
         #1;
         checks++; if (state !== es[i]) begin errors++; $display("FAIL lw_state step %0d got %0d expected %0d", i, state, es[i]); end
         if (i == 3) begin
            checks++; if ({adr_src, result_src} !== 3'b100) begin errors++; $display("FAIL lw_memread_ctl got %b expected 100", {adr_src, result_src}); end
         end
         if (i == 6) begin
            checks++; if ({result_src, reg_write} !== 3'b011) begin errors++; $display("FAIL lw_memwb_ctl got %b expected 011", {result_src, reg_write}); end
         end
         @(negedge clk);
      end
      exp_retired = exp_retired + 32'd1;
      checks++; if (retired !== exp_retired) begin errors++; $display("FAIL lw_retired got %0d expected %0d", retired, exp_retired); end
   endtask

   task automatic test_fetch_stall();
      logic [3:0] es [8] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd11, 4'd7, 4'd0};
      logic       mr [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      opcode = 7'b0110111;
      for (int i = 0; i < 8; i++) begin
         mem_ready = mr[i];
         #1;
         checks++; if (state !== es[i]) begin errors++; $display("FAIL fstall_state step %0d got %0d expected %0d", i, state, es[i]); end
         if (i < 4) begin
            checks++; if ({ir_write, pc_update} !== {mr[i], mr[i]}) begin errors++; $display("FAIL fstall_we step %0d got %b expected %b", i, {ir_write, pc_update}, {mr[i], mr[i]}); end
         end
         if (i == 5) begin
            checks++; if ({alu_src_a, alu_src_b, alu_op} !== 6'b11_01_00) begin errors++; $display("FAIL lui_ctl got %b expected 110100", {alu_src_a, alu_src_b, alu_op}); end
         end
         @(negedge clk);
      end
      exp_retired = exp_retired + 32'd1;
      checks++; if (retired !== exp_retired) begin errors++; $display("FAIL fstall_retired got %0d expected %0d", retired, exp_retired); end
   endtask

   task automatic test_illegal();
      logic [3:0] es  [4] = '{4'd0, 4'd1, 4'd0, 4'd0};
      logic       mr  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic       ill [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      opcode = 7'b1111111;
      for (int i = 0; i < 4; i++) begin
         mem_ready = mr[i];
         #1;
         checks++; if (state !== es[i]) begin errors++; $display("FAIL illegal_state step %0d got %0d expected %0d", i, state, es[i]); end
         checks++; if (illegal !== ill[i]) begin errors++; $display("FAIL illegal_pulse step %0d got %0d expected %0d", i, illegal, ill[i]); end
         checks++; if ({reg_write, mem_write} !== 2'b00) begin errors++; $display("FAIL illegal_we step %0d got %b expected 00", i, {reg_write, mem_write}); end
         @(negedge clk);
      end
      checks++; if (retired !== exp_retired) begin errors++; $display("FAIL illegal_retired got %0d expected %0d", retired, exp_retired); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] es  [14] = '{4'd0, 4'd1, 4'd8, 4'd7, 4'd0, 4'd1, 4'd9, 4'd7, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd0};
      logic       mr  [14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic       rw  [14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic       mw  [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic       pcu [14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [6:0] op  [14] = '{7'h13, 7'h13, 7'h13, 7'h13, 7'h6F, 7'h6F, 7'h6F, 7'h6F, 7'h23, 7'h23, 7'h23, 7'h23, 7'h23, 7'h23};
      for (int i = 0; i < 14; i++) begin
         mem_ready = mr[i];
         opcode    = op[i];
         #1;
         checks++; if (state !== es[i]) begin errors++; $display("FAIL b2b_state step %0d got %0d expected %0d", i, state, es[i]); end
         checks++; if ({reg_write, mem_write, pc_update} !== {rw[i], mw[i], pcu[i]}) begin errors++; $display("FAIL b2b_we step %0d got %b expected %b", i, {reg_write, mem_write, pc_update}, {rw[i], mw[i], pcu[i]}); end
         if (i == 1) begin
            checks++; if ({alu_src_a, alu_src_b, alu_op} !== 6'b01_01_00) begin errors++; $display("FAIL decode_ctl got %b expected 010100", {alu_src_a, alu_src_b, alu_op}); end
         end
         if (i == 2) begin
            checks++; if ({alu_src_a, alu_src_b, alu_op} !== 6'b10_01_10) begin errors++; $display("FAIL execi_ctl got %b expected 100110", {alu_src_a, alu_src_b, alu_op}); end
         end
         if (i == 6) begin
            checks++; if ({alu_src_a, alu_src_b, result_src} !== 6'b01_10_00) begin errors++; $display("FAIL jal_ctl got %b expected 011000", {alu_src_a, alu_src_b, result_src}); end
         end
         if (i == 11) begin
            checks++; if (adr_src !== 1'b1) begin errors++; $display("FAIL sw_adr_src got %0d expected 1", adr_src); end
         end
         @(negedge clk);
      end
      exp_retired = exp_retired + 32'd3;
      checks++; if (retired !== exp_retired) begin errors++; $display("FAIL b2b_retired got %0d expected %0d", retired, exp_retired); end
   endtask

   task automatic test_reset_mid_sw();
      logic [3:0] es [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
      logic       mr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      opcode = 7'b0100011;
      for (int i = 0; i < 4; i++) begin
         mem_ready = mr[i];
         #1;
         checks++; if (state !== es[i]) begin errors++; $display("FAIL swrst_state step %0d got %0d expected %0d", i, state, es[i]); end
         @(negedge clk);
      end
      #1;
      checks++; if ({state, mem_write} !== {4'd5, 1'b1}) begin errors++; $display("FAIL swrst_held got %b expected 01011", {state, mem_write}); end
      reset = 1'b0;
      #1;
      exp_retired = 32'd0;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL swrst_async_state got %0d expected 0", state); end
      checks++; if ({mem_write, reg_write} !== 2'b00) begin errors++; $display("FAIL swrst_async_we got %b expected 00", {mem_write, reg_write}); end
      checks++; if (retired !== exp_retired) begin errors++; $display("FAIL swrst_retired got %0d expected 0", retired); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_unused_state();
      mem_ready = 1'b1;
      force dut.r_state = 4'd12;
      #1;
      checks++; if (state !== 4'd12) begin errors++; $display("FAIL unused_forced got %0d expected 12", state); end
      checks++; if ({pc_update, branch, ir_write, reg_write, mem_write, adr_src, result_src, alu_op, alu_src_a, alu_src_b} !== 14'd0) begin
         errors++; $display("FAIL unused_outputs got %b expected 0", {pc_update, branch, ir_write, reg_write, mem_write, adr_src, result_src, alu_op, alu_src_a, alu_src_b});
      end
      mem_ready = 1'b0;
      release dut.r_state;
      @(negedge clk);
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL unused_exit got %0d expected 0", state); end
   endtask

   task automatic test_wrap();
      opcode = 7'b1100011;
      mem_ready = 1'b1;
      force dut.r_retired = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.r_retired;
      mem_ready = 1'b0;
      #1;
      checks++; if ({state, retired} !== {4'd1, 32'hFFFF_FFFF}) begin errors++; $display("FAIL wrap_preload got %h expected 1ffffffff", {state, retired}); end
      @(negedge clk);
      #1;
      checks++; if (state !== 4'd10) begin errors++; $display("FAIL beq_state got %0d expected 10", state); end
      checks++; if ({branch, alu_op, alu_src_a, alu_src_b, result_src} !== 9'b1_01_10_00_00) begin errors++; $display("FAIL beq_ctl got %b expected 101100000", {branch, alu_op, alu_src_a, alu_src_b, result_src}); end
      @(negedge clk);
      #1;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL wrap_state got %0d expected 0", state); end
      checks++; if (retired !== 32'd0) begin errors++; $display("FAIL wrap_retired got %h expected 00000000", retired); end
   endtask

   initial begin
      reset     = 1'b0;
      mem_ready = 1'b0;
      opcode    = 7'd0;
      test_reset();
      test_rtype();
      test_lw_stall();
      test_fetch_stall();
      test_illegal();
      test_back_to_back();
      test_reset_mid_sw();
      test_unused_state();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
